// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: RV32I control-flow opcodes and controller states.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      StFetch    = 3'd0,
      StDispatch = 3'd1,
      StExec     = 3'd2,
      StError    = 3'd3,
      StTrap     = 3'd4
   } state_e;

   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection for JAL, JALR, conditional branches and sequential flow.
module fetch_sequencer_next_pc_calc
   import fetch_sequencer_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [6:0]  opcode,
   input  logic [31:0] imm_value,
   input  logic [31:0] rs1_value,
   input  logic        br_taken,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] seq_pc;
   logic [31:0] rel_pc;
   logic [31:0] jalr_pc;

   always_comb begin
      seq_pc  = pc + 32'd4;
      rel_pc  = pc + imm_value;
      jalr_pc = (rs1_value + imm_value) & ~32'd1;
      next_pc = seq_pc;
      case (opcode)
         OpcJal:    next_pc = rel_pc;
         OpcJalr:   next_pc = jalr_pc;
         OpcBranch: next_pc = br_taken ? rel_pc : seq_pc;
         OpcLoad, OpcStore, OpcOpImm, OpcLui, OpcAuipc: next_pc = seq_pc;
         default:   next_pc = seq_pc;
      endcase
      misaligned = !is_word_aligned(next_pc);
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/dispatch controller. Define MISALIGN_TRAP_EN to trap on misaligned targets
// instead of silently clearing next_pc[1:0].
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        ex_ready,
   input  logic        ex_done,
   input  logic [31:0] imm_value,
   input  logic [31:0] rs1_value,
   input  logic        br_taken,
   output logic [31:0] link_value,
   output logic [31:0] retire_count,
   output logic        fetch_err,
   output logic        misalign_trap,
   output logic [31:0] trap_pc
);

   localparam int unsigned CntW = $clog2(FETCH_TIMEOUT);
   localparam logic [CntW-1:0] CntMax = CntW'(FETCH_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic [31:0]       retire_q, retire_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              fetch_err_q, fetch_err_d;
   logic              imem_req_q, imem_req_d;
   logic              instr_valid_q, instr_valid_d;
   logic              retire;
   logic [31:0]       next_pc;
   logic              misaligned;

   fetch_sequencer_next_pc_calc u_next_pc_calc (
      .pc         (pc_q),
      .opcode     (instr_q[6:0]),
      .imm_value  (imm_value),
      .rs1_value  (rs1_value),
      .br_taken   (br_taken),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

`ifdef MISALIGN_TRAP_EN
   logic              misalign_trap_q, misalign_trap_d;
   logic [31:0]       trap_pc_q, trap_pc_d;
`else
   logic              unused_misaligned;
   assign unused_misaligned = misaligned ^ (|next_pc[1:0]);
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      retire_d      = retire_q;
      cnt_d         = cnt_q;
      fetch_err_d   = fetch_err_q;
      retire        = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap_d = misalign_trap_q;
      trap_pc_d       = trap_pc_q;
`endif
      case (state_q)
         StFetch: begin
            // An ack seen before our request is up belongs to a pre-reset fetch.
            if (imem_req_q && imem_ack) begin
               instr_d    = imem_rdata;
               instr_pc_d = pc_q;
               cnt_d      = '0;
               state_d    = StDispatch;
            end else if (imem_req_q) begin
               if (cnt_q == CntMax) begin
                  fetch_err_d = 1'b1;
                  state_d     = StError;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDispatch: begin
            if (ex_ready) begin
               if (ex_done) retire = 1'b1;
               else         state_d = StExec;
            end
         end
         StExec: begin
            if (ex_done) retire = 1'b1;
         end
         default: ;
      endcase

      if (retire) begin
`ifdef MISALIGN_TRAP_EN
         if (misaligned) begin
            trap_pc_d       = pc_q;
            misalign_trap_d = 1'b1;
            state_d         = StTrap;
         end else begin
            pc_d     = next_pc;
            retire_d = retire_q + 32'd1;
            state_d  = StFetch;
         end
`else
         pc_d     = {next_pc[31:2], 2'b00};
         retire_d = retire_q + 32'd1;
         state_d  = StFetch;
`endif
      end

      imem_req_d    = (state_d == StFetch);
      instr_valid_d = (state_d == StDispatch);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StFetch;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         retire_q      <= '0;
         cnt_q         <= '0;
         fetch_err_q   <= 1'b0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         retire_q      <= retire_d;
         cnt_q         <= cnt_d;
         fetch_err_q   <= fetch_err_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_trap_q <= 1'b0;
         trap_pc_q       <= '0;
      end else begin
         misalign_trap_q <= misalign_trap_d;
         trap_pc_q       <= trap_pc_d;
      end
   end
   assign misalign_trap = misalign_trap_q;
   assign trap_pc       = trap_pc_q;
`else
   assign misalign_trap = 1'b0;
   assign trap_pc       = '0;
`endif

   assign imem_req     = imem_req_q;
   assign imem_addr    = pc_q;
   assign instr        = instr_q;
   assign instr_pc     = instr_pc_q;
   assign instr_valid  = instr_valid_q;
   assign link_value   = pc_q + 32'd4;
   assign retire_count = retire_q;
   assign fetch_err    = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with RESET_PC=0x100, FETCH_TIMEOUT=16; honours MISALIGN_TRAP_EN.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        ex_ready;
   logic        ex_done;
   logic [31:0] imm_value;
   logic [31:0] rs1_value;
   logic        br_taken;
   logic [31:0] link_value;
   logic [31:0] retire_count;
   logic        fetch_err;
   logic        misalign_trap;
   logic [31:0] trap_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .RESET_PC      (32'h0000_0100),
      .FETCH_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .ex_ready      (ex_ready),
      .ex_done       (ex_done),
      .imm_value     (imm_value),
      .rs1_value     (rs1_value),
      .br_taken      (br_taken),
      .link_value    (link_value),
      .retire_count  (retire_count),
      .fetch_err     (fetch_err),
      .misalign_trap (misalign_trap),
      .trap_pc       (trap_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request, check its address, then ack it for one cycle.
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
      for (int i = 0; i < 8; i++) begin
         if (imem_req === 1'b1) break;
         step();
      end
      check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      check({tag, "_addr"}, imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = word;
      step();
      imem_ack   = 1'b0;
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_instr"}, instr, word);
      check({tag, "_ipc"}, instr_pc, addr);
   endtask

   task automatic retire(input logic [31:0] imm, input logic [31:0] rs1, input logic taken);
      ex_ready  = 1'b1;
      ex_done   = 1'b1;
      imm_value = imm;
      rs1_value = rs1;
      br_taken  = taken;
      step();
      ex_ready = 1'b0;
      ex_done  = 1'b0;
      br_taken = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      ex_ready   = 1'b0;
      ex_done    = 1'b0;
      imm_value  = '0;
      rs1_value  = '0;
      br_taken   = 1'b0;
      step();
      step();

      // Reset state
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h100);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_count", retire_count, 32'd0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);
      check("rst_trap", {31'd0, misalign_trap}, 32'd0);
      check("rst_link", link_value, 32'h104);

      rst_n = 1'b1;
      step();
      check("first_req", {31'd0, imem_req}, 32'd1);

      // 1: sequential instruction
      fetch("t1", 32'h100, 32'h0050_0093);
      check("t1_req_low", {31'd0, imem_req}, 32'd0);
      retire(32'd5, 32'd0, 1'b0);
      check("t1_next_req", {31'd0, imem_req}, 32'd1);
      check("t1_next_addr", imem_addr, 32'h104);
      check("t1_count", retire_count, 32'd1);
      check("t1_valid_low", {31'd0, instr_valid}, 32'd0);

      // 2: JAL
      fetch("t2", 32'h104, 32'h0200_006F);
      check("t2_link", link_value, 32'h108);
      retire(32'h20, 32'd0, 1'b0);
      check("t2_addr", imem_addr, 32'h124);
      check("t2_count", retire_count, 32'd2);

      // 3: branch not taken, then taken backwards
      fetch("t3a", 32'h124, 32'h0000_0063);
      retire(32'hFFFF_FFF8, 32'd0, 1'b0);
      check("t3a_addr", imem_addr, 32'h128);
      fetch("t3b", 32'h128, 32'h0000_0063);
      retire(32'hFFFF_FFF8, 32'd0, 1'b1);
      check("t3b_addr", imem_addr, 32'h120);
      check("t3b_count", retire_count, 32'd4);

      // 6a: done before ready is ignored; ready then done through EXEC
      fetch("t6a", 32'h120, 32'h0000_0013);
      ex_done = 1'b1;
      step();
      ex_done = 1'b0;
      check("t6a_still_valid", {31'd0, instr_valid}, 32'd1);
      check("t6a_no_retire", retire_count, 32'd4);
      ex_ready = 1'b1;
      step();
      ex_ready = 1'b0;
      check("t6a_exec_valid", {31'd0, instr_valid}, 32'd0);
      check("t6a_exec_req", {31'd0, imem_req}, 32'd0);
      step();
      check("t6a_wait_count", retire_count, 32'd4);
      imm_value = 32'h40;
      ex_done   = 1'b1;
      step();
      ex_done = 1'b0;
      check("t6a_addr", imem_addr, 32'h124);
      check("t6a_count", retire_count, 32'd5);

      // 4: JALR to a misaligned target
      fetch("t4", 32'h124, 32'h0000_0067);
      retire(32'd0, 32'h203, 1'b0);
`ifdef MISALIGN_TRAP_EN
      check("t4_trap", {31'd0, misalign_trap}, 32'd1);
      check("t4_trap_pc", trap_pc, 32'h124);
      check("t4_count", retire_count, 32'd5);
      step();
      step();
      check("t4_req_low", {31'd0, imem_req}, 32'd0);
      check("t4_pc_frozen", imem_addr, 32'h124);
`else
      check("t4_req", {31'd0, imem_req}, 32'd1);
      check("t4_addr", imem_addr, 32'h200);
      check("t4_count", retire_count, 32'd6);
      check("t4_trap", {31'd0, misalign_trap}, 32'd0);
      check("t4_trap_pc", trap_pc, 32'd0);
`endif

      // 6b: reset pulse in the middle of EXEC, with a stale ack in flight
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      fetch("t6b", 32'h100, 32'h0000_0013);
      ex_ready = 1'b1;
      step();
      ex_ready = 1'b0;
      #3;
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      check("t6b_valid", {31'd0, instr_valid}, 32'd0);
      check("t6b_count", retire_count, 32'd0);
      check("t6b_instr", instr, 32'd0);
      check("t6b_trap", {31'd0, misalign_trap}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0;
      check("t6b_req", {31'd0, imem_req}, 32'd1);
      check("t6b_addr", imem_addr, 32'h100);
      check("t6b_stale_ack", instr, 32'd0);

      // 5: no ack -> timeout after 16 request cycles, then terminal
      for (int i = 0; i < 15; i++) step();
      check("t5_req_before", {31'd0, imem_req}, 32'd1);
      check("t5_err_before", {31'd0, fetch_err}, 32'd0);
      step();
      check("t5_err", {31'd0, fetch_err}, 32'd1);
      check("t5_req_low", {31'd0, imem_req}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 50; i++) begin
         step();
         imem_ack = 1'b0;
         check("t5_hold_req", {31'd0, imem_req}, 32'd0);
         check("t5_hold_err", {31'd0, fetch_err}, 32'd1);
      end
      check("t5_hold_instr", instr, 32'd0);
      check("t5_hold_valid", {31'd0, instr_valid}, 32'd0);

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("t5_rec_req", {31'd0, imem_req}, 32'd1);
      check("t5_rec_addr", imem_addr, 32'h100);
      check("t5_rec_err", {31'd0, fetch_err}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
